sram_rw_ctrl_8x200: RTL
=======================

# sram_rw_ctrl_8x200

Front-end controller for the 8-entry x 200-bit single-port SRAM macro (one shared RW port, two 100-bit write-mask lanes). It arbitrates independent write and read request channels onto the single port, one access per cycle, and buffers read data in a 2-entry response FIFO with valid/ready backpressure. It can optionally zero-fill the array after reset. Sits directly upstream of the SRAM: it drives the macro's address, enable, write-mode, mask and write-data pins and consumes its read data.

## Interface
Parameters: none (geometry fixed: 8 entries, 200 bits, 2 mask lanes of 100 bits).

Ports:
- clock  in  1  single clock; also drives the SRAM macro clock
- reset_n  in  1  asynchronous, active-low reset
- w_valid  in  1  write request valid
- w_ready  out  1  write request accepted
- w_addr  in  3  write entry index
- w_mask  in  2  bit i enables data bits [i*100 +: 100]
- w_data  in  200  write data
- r_req_valid  in  1  read request valid
- r_req_ready  out  1  read request accepted
- r_addr  in  3  read entry index
- r_resp_valid  out  1  read response valid (FIFO head)
- r_resp_ready  in  1  consumer takes the response
- r_resp_data  out  200  read response data
- sram_addr  out  3  to SRAM address
- sram_en  out  1  to SRAM enable
- sram_wmode  out  1  to SRAM write mode (1 = write)
- sram_wmask  out  2  to SRAM write mask
- sram_wdata  out  200  to SRAM write data
- sram_rdata  in  200  from SRAM; valid the cycle after a read enable
- init_done  out  1  controller is in RUN

## Operation
- States: BOOT (reset value), INIT, RUN.
  - BOOT -> INIT on the first edge after reset release, or BOOT -> RUN when init is compiled out.
  - INIT: 3-bit sweep counter 0..7. Each cycle: sram_en=1, wmode=1, wmask=2'b11, wdata=0, addr=counter. At count 7 -> RUN.
  - RUN is terminal until reset.
- SRAM pins are combinational from the current state and grant, so the accept cycle is the SRAM access cycle. When idle: sram_en=0, and all other SRAM outputs are 0.
- Arbitration in RUN, at most one grant per cycle:
  - A read is eligible only if credit allows: fifo_count − deq + inflight < 2, where deq = r_resp_valid && r_resp_ready and inflight = read issued last cycle.
  - Default: write wins.
  - Starvation guard: a 2-bit counter counts consecutive write grants while an eligible read was denied. When it reaches 3, the next cycle grants the eligible read over a pending write. The counter clears on any read grant, or on any cycle with no eligible read pending.
  - w_ready = RUN && w_valid && write granted.
  - r_req_ready = RUN && r_req_valid && read granted.
  - Both readies are never 1 in the same cycle.
- Write grant: drive sram_addr/wmask/wdata from the request. w_mask=2'b00 is still a granted, accepted no-op write.
- Read grant: en=1, wmode=0, addr=r_addr; set inflight. The next cycle, push sram_rdata into the FIFO.
- FIFO: 2 entries, in order. Push and pop in the same cycle are legal at any count. Overflow cannot occur because of credit; the bench asserts this.
- Read-after-write to the same address returns the new data, since the write completes before the later read's access cycle.
- Asynchronous reset mid-operation: state returns to BOOT, and FIFO, inflight, counters and outputs clear immediately. Any in-flight response is discarded.

## Timing
- Reset values: w_ready=0, r_req_ready=0, r_resp_valid=0, r_resp_data=0, sram_en=0, sram_wmode=0, sram_addr=0, sram_wmask=0, sram_wdata=0, init_done=0.
- Init enabled: edge E0 after reset release -> INIT. Sweep writes occur in cycles E0–E7. RUN and init_done=1 from edge E8 onward.
- Init disabled: RUN and init_done=1 from edge E0.
- Read latency: request accepted in cycle T -> r_resp_valid=1 in cycle T+2 (SRAM data at T+1, registered into the FIFO).
- Throughput: 1 read/cycle sustained while r_resp_ready=1. Reads stall after 2 outstanding unconsumed responses.

## Configuration
- SRAM_CTRL_INIT_EN defined: BOOT -> INIT zero-sweep of all 8 entries, as above.
- Not defined: no INIT state or sweep counter. BOOT -> RUN directly. Array contents are undefined until written.

## Test plan
- Reset, init enabled: release reset -> 8 writes, addr 0..7, wmask=2'b11, wdata=0. init_done rises at E8. Reads of all entries return 0.
- Write addr 3, mask 2'b01, data lanes {A,B}; then read addr 3 -> response lane0=B, lane1=0. Response appears 2 cycles after read accept.
- Streaming reads addr 0..7 with r_resp_ready=1 -> r_req_ready high every cycle, 8 responses in order. Hold r_resp_ready=0 -> exactly 2 reads accepted, then r_req_ready=0 until a pop.
- w_valid and r_req_valid held high continuously -> grant pattern W,W,W,R repeating. Never both readies in one cycle.
- Assert reset_n low with 2 responses queued and 1 in flight -> all outputs at reset values immediately. After re-release, no stale response appears.
- Init compiled out: init_done=1 and requests accepted from the first edge after reset release. No sweep writes observed on the SRAM pins.

Source files
------------

// File: rtl/sram_rw_ctrl_8x200.sv
// Write/read arbiter for an 8x200 single-port SRAM, with a 2-deep read response FIFO.
// Define SRAM_CTRL_INIT_EN to zero-fill all 8 entries after reset.
module sram_rw_ctrl_8x200 (
  input  logic         clock,
  input  logic         reset_n,
  input  logic         w_valid,
  output logic         w_ready,
  input  logic [2:0]   w_addr,
  input  logic [1:0]   w_mask,
  input  logic [199:0] w_data,
  input  logic         r_req_valid,
  output logic         r_req_ready,
  input  logic [2:0]   r_addr,
  output logic         r_resp_valid,
  input  logic         r_resp_ready,
  output logic [199:0] r_resp_data,
  output logic [2:0]   sram_addr,
  output logic         sram_en,
  output logic         sram_wmode,
  output logic [1:0]   sram_wmask,
  output logic [199:0] sram_wdata,
  input  logic [199:0] sram_rdata,
  output logic         init_done
);
  localparam int unsigned DATA_W = 200;

`ifdef SRAM_CTRL_INIT_EN
  typedef enum logic [1:0] {ST_BOOT = 2'd0, ST_INIT = 2'd1, ST_RUN = 2'd2} state_t;
`else
  typedef enum logic [1:0] {ST_BOOT = 2'd0, ST_RUN = 2'd2} state_t;
`endif

  state_t      r_state;
  logic        r_inflight;
  logic [1:0]  r_starve_cnt;
  logic        r_fifo_wptr;
  logic        r_fifo_rptr;
  logic [1:0]  r_fifo_cnt;

  logic        w_run;
  logic        w_in_init;
  logic [2:0]  w_init_addr;
  logic        w_deq;
  logic        w_push;
  logic [2:0]  w_credit;
  logic        w_rd_elig;
  logic        w_wr_pend;
  logic        w_grant_rd;
  logic        w_grant_wr;
  logic [DATA_W-1:0] w_fifo_head;

`ifdef SRAM_CTRL_INIT_EN
  logic [2:0]  r_init_cnt;
  assign w_in_init   = (r_state == ST_INIT);
  assign w_init_addr = r_init_cnt;
`else
  assign w_in_init   = 1'b0;
  assign w_init_addr = 3'd0;
`endif

  assign w_run     = (r_state == ST_RUN);
  assign init_done = w_run;

  // Reads are only issued if the FIFO can hold every response already in flight.
  assign w_deq      = r_resp_valid && r_resp_ready;
  assign w_push     = r_inflight;
  assign w_credit   = {1'b0, r_fifo_cnt} - {2'b00, w_deq} + {2'b00, r_inflight};
  assign w_rd_elig  = w_run && r_req_valid && (w_credit < 3'd2);
  assign w_wr_pend  = w_run && w_valid;
  assign w_grant_rd = w_rd_elig && (!w_wr_pend || (r_starve_cnt == 2'd3));
  assign w_grant_wr = w_wr_pend && !w_grant_rd;

  assign w_ready     = w_grant_wr;
  assign r_req_ready = w_grant_rd;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= ST_BOOT;
`ifdef SRAM_CTRL_INIT_EN
      r_init_cnt <= 3'd0;
`endif
    end else begin
      case (r_state)
        ST_BOOT: begin
`ifdef SRAM_CTRL_INIT_EN
          r_state    <= ST_INIT;
          r_init_cnt <= 3'd0;
`else
          r_state <= ST_RUN;
`endif
        end
`ifdef SRAM_CTRL_INIT_EN
        ST_INIT: begin
          r_init_cnt <= r_init_cnt + 3'd1;
          if (r_init_cnt == 3'd7) begin
            r_state <= ST_RUN;
          end
        end
`endif
        ST_RUN:  r_state <= ST_RUN;
        default: r_state <= ST_BOOT;
      endcase
    end
  end

  // Starvation counter: consecutive write wins over an eligible read.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_inflight   <= 1'b0;
      r_starve_cnt <= 2'd0;
    end else begin
      r_inflight <= w_grant_rd;
      if (w_grant_rd || !w_rd_elig) begin
        r_starve_cnt <= 2'd0;
      end else if (w_grant_wr && (r_starve_cnt != 2'd3)) begin
        r_starve_cnt <= r_starve_cnt + 2'd1;
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_fifo_wptr <= 1'b0;
      r_fifo_rptr <= 1'b0;
      r_fifo_cnt  <= 2'd0;
    end else begin
      if (w_push) begin
        r_fifo_wptr <= ~r_fifo_wptr;
      end
      if (w_deq) begin
        r_fifo_rptr <= ~r_fifo_rptr;
      end
      r_fifo_cnt <= r_fifo_cnt + {1'b0, w_push} - {1'b0, w_deq};
    end
  end

  for (genvar gi = 0; gi < 2; gi++) begin : g_fifo
    localparam logic IDX = 1'(gi);
    logic [DATA_W-1:0] r_entry;
    always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
        r_entry <= '0;
      end else if (w_push && (r_fifo_wptr == IDX)) begin
        r_entry <= sram_rdata;
      end
    end
  end

  assign w_fifo_head  = r_fifo_rptr ? g_fifo[1].r_entry : g_fifo[0].r_entry;
  assign r_resp_valid = (r_fifo_cnt != 2'd0);
  assign r_resp_data  = r_resp_valid ? w_fifo_head : '0;

  // SRAM pins follow the grant in the same cycle; everything is zero when idle.
  always_comb begin
    sram_en    = 1'b0;
    sram_wmode = 1'b0;
    sram_addr  = 3'd0;
    sram_wmask = 2'b00;
    sram_wdata = '0;
    if (w_in_init) begin
      sram_en    = 1'b1;
      sram_wmode = 1'b1;
      sram_wmask = 2'b11;
      sram_addr  = w_init_addr;
    end else if (w_grant_wr) begin
      sram_en    = 1'b1;
      sram_wmode = 1'b1;
      sram_wmask = w_mask;
      sram_addr  = w_addr;
      sram_wdata = w_data;
    end else if (w_grant_rd) begin
      sram_en   = 1'b1;
      sram_addr = r_addr;
    end
  end

endmodule
